mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multi-cycle main control unit for the MIPS core.
- Sequences the shared ALU, register file, instruction register and unified memory port across FETCH/DECODE/EXECUTE/MEM/WB cycles.
- Drives the 2-bit alu_op consumed by the ALU control decoder.
- Handshakes with a variable-latency memory through mem_ready, with a timeout watchdog.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for mem_ready in any memory state before aborting.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction bits [31:26] from IR
- funct  input  6  instruction bits [5:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified by zero (beq)
- i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- mem_to_reg  output  1  write-back data select: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  destination register: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  output  2  00 add, 01 sub, 10 use funct, 11 shift
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_err  output  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, wait counter=0 and every output to 0.
- First rising clk edge after release moves IDLE to FETCH.
- Outputs are decoded from the registered state (Moore). Exceptions, which are also gated by mem_ready: ir_write, pc_write in FETCH, and the MEM states' exit.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC
  - any other -> FETCH, with illegal_op=1 for that DECODE cycle
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. Exits to LW_WB when mem_ready=1.
- LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Exits to FETCH when mem_ready=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- Latency with mem_ready tied to 1:
  - R-type, addi: 4 cycles each.
  - lw: 5 cycles. sw: 4 cycles.
  - beq, j: 3 cycles each.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle spent in such a state with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: mem_err=1 for that cycle, the FSM goes to FETCH, and no write enables assert. A MEM_WR timeout drops the store. A FETCH timeout retries the fetch.
  - mem_ready=1 on the timeout cycle wins: normal completion, no mem_err.
- rst_n assertion mid-instruction aborts immediately; no partial write-back completes.

Optional Feature:
- SHIFT_OP_EN defined: in R_EXEC, opcode=000000 with funct 000000 (sll) or 000010 (srl) drives alu_op=11. All other functs drive 10.
- Undefined: R_EXEC always drives alu_op=10; shift functs are left to the ALU control decoder's default.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum, 4-bit encoding
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_op constants: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_SHIFT
  - alu_src_b and pc_source select constants
- One natural sub-module: mem_wait_timer. It holds the counter plus the timeout compare, with inputs clr/en/ready and output expired.

Test Plan:
- Reset pulse mid-MEM_RD -> all outputs 0 immediately; FETCH one cycle after release, with counter=0.
- lw (opcode 100011), mem_ready=1 always -> states FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB; reg_write=1 only in cycle 5, with mem_to_reg=1 and reg_dst=0.
- sw with mem_ready held low 3 cycles in MEM_WR -> mem_write held 4 cycles; FETCH on the cycle after mem_ready=1; reg_write never asserts.
- beq with zero=1 -> pc_write_cond=1, pc_source=01 in cycle 3. Opcode 111111 -> illegal_op pulse in DECODE, then FETCH.
- FETCH with mem_ready=0 for TIMEOUT=16 cycles -> mem_err pulse on cycle 16; ir_write never asserts; FETCH re-entered with counter cleared.
- R-type with funct 000000 -> alu_op=11 in R_EXEC when SHIFT_OP_EN is defined, 10 when it is not. funct 100000 -> alu_op=10 in both builds.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_LW_WB     = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SHIFT = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are covered by the watchdog.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_wait_timer.sv
// Memory wait counter with timeout compare for the control FSM watchdog.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic ready,
  output logic expired
);

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle counter: cleared on entry to a memory state, counts stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !ready) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // The stall cycle that would make TIMEOUT waits is the expiring one.
  assign expired = en && !ready && (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM with memory handshake watchdog.
// Build option: define SHIFT_OP_EN to drive alu_op=11 for sll/srl in R_EXEC.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err
);

  state_t state_r;
  state_t state_next_s;
  logic   wait_clr_s;
  logic   wait_en_s;
  logic   expired_s;
  logic   unused_ok_s;

  // zero qualifies pc_write_cond in the datapath; funct only matters with shifts enabled.
  assign unused_ok_s = ^{zero, funct};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // A timed-out FETCH re-enters itself, so it must clear the counter too.
  assign wait_en_s  = is_mem_state(state_r);
  assign wait_clr_s = is_mem_state(state_next_s) && ((state_next_s != state_r) || expired_s);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr_s),
    .en      (wait_en_s),
    .ready   (mem_ready),
    .expired (expired_s)
  );

  // Next-state and output decode from the registered state.
  always_comb begin
    state_next_s  = state_r;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;
    case (state_r)
      S_IDLE: state_next_s = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          state_next_s = S_DECODE;
        end else if (expired_s) begin
          mem_err      = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     state_next_s = S_R_EXEC;
          OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_J:         state_next_s = S_JUMP;
          OP_ADDI:      state_next_s = S_ADDI_EXEC;
          default: begin
            illegal_op   = 1'b1;
            state_next_s = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
`ifdef SHIFT_OP_EN
        if ((opcode == OP_RTYPE) && ((funct == FUNCT_SLL) || (funct == FUNCT_SRL))) begin
          alu_op = ALUOP_SHIFT;
        end else begin
          alu_op = ALUOP_FUNCT;
        end
`endif
        state_next_s = S_R_WB;
      end
      S_R_WB: begin
        reg_dst      = 1'b1;
        reg_write    = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_next_s = S_MEM_RD;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_next_s = S_LW_WB;
        end else if (expired_s) begin
          mem_err      = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEM_RD;
        end
      end
      S_LW_WB: begin
        mem_to_reg   = 1'b1;
        reg_write    = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d = 1'b1;
        // The write strobe is withheld on the abort cycle so the store is dropped.
        if (mem_ready) begin
          mem_write    = 1'b1;
          state_next_s = S_FETCH;
        end else if (expired_s) begin
          mem_err      = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          mem_write    = 1'b1;
          state_next_s = S_MEM_WR;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_next_s  = S_FETCH;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pc_source    = PCSRC_JUMP;
        state_next_s = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        state_next_s = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write    = 1'b1;
        state_next_s = S_FETCH;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

endmodule
